// File: rtl/vpu_writeback.sv
// Writeback stage: per-column skew FIFOs re-aligned into N-wide rows written to the unified buffer.

// Per-column FIFO with a synchronous flush; push into a full FIFO only lands when a pop frees a slot.
// Latency: a word pushed at an edge is the visible head from the following cycle.
// Backpressure: none internal; the caller sees full and decides whether to drop.
module vpu_wb_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // Storage is cleared so the combinational head is never X.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Collects skewed VPU column words and writes aligned rows to consecutive UB addresses.
// Latency: a row is presented the cycle after its last column word is pushed; no output registers.
// Backpressure: ub_wr_ready low holds the row stable; FIFOs absorb input; a push to a full FIFO drops and sets overflow.
module vpu_writeback #(
    parameter int N      = 2,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_rows,
    input  logic [N*16-1:0]   vpu_data_in,
    input  logic [N-1:0]      vpu_valid_in,
    input  logic              ub_wr_ready,
    output logic              ub_wr_valid,
    output logic [ADDR_W-1:0] ub_wr_addr,
    output logic [N*16-1:0]   ub_wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] num_q;
    logic [ADDR_W-1:0] rows_done;
    logic [N-1:0]      push_en;
    logic [N-1:0]      full_w;
    logic [N-1:0]      empty_w;
    logic [N-1:0]      ovf_hit;
    logic              fire;
    logic              last_row;
    logic              accept_start;

    assign accept_start = (state == IDLE) & start;
    assign ub_wr_valid  = (state == RUN) & ~|empty_w;
    assign fire         = ub_wr_valid & ub_wr_ready;
    assign last_row     = (rows_done == num_q - ADDR_W'(1));
    assign ub_wr_addr   = base_q + rows_done;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    for (genvar j = 0; j < N; j++) begin : g_col
        assign push_en[j] = (state == RUN) & vpu_valid_in[j];
        // A simultaneous pop frees the slot, so only a push without a fire is lost.
        assign ovf_hit[j] = push_en[j] & full_w[j] & ~fire;

        vpu_wb_fifo #(.W(16), .DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (state == DONE),
            .push      (push_en[j]),
            .push_data (vpu_data_in[16*j +: 16]),
            .pop       (fire),
            .head      (ub_wr_data[16*j +: 16]),
            .full      (full_w[j]),
            .empty     (empty_w[j])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (num_rows == '0) ? DONE : RUN;
            RUN:  if (fire && last_row) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base_q    <= '0;
            num_q     <= '0;
            rows_done <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept_start) begin
                base_q    <= base_addr;
                num_q     <= num_rows;
                rows_done <= '0;
                overflow  <= 1'b0;
            end else begin
                if (fire) rows_done <= rows_done + ADDR_W'(1);
                if (|ovf_hit) overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vpu_writeback.sv
// Directed bench for vpu_writeback (N=2, DEPTH=4, ADDR_W=16).
module tb_vpu_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] num_rows;
    logic [31:0] vpu_data_in;
    logic [1:0]  vpu_valid_in;
    logic        ub_wr_ready;
    logic        ub_wr_valid;
    logic [15:0] ub_wr_addr;
    logic [31:0] ub_wr_data;
    logic        busy;
    logic        done;
    logic        overflow;

    int vectors = 0;
    int errors  = 0;

    vpu_writeback #(.N(2), .DEPTH(4), .ADDR_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .num_rows     (num_rows),
        .vpu_data_in  (vpu_data_in),
        .vpu_valid_in (vpu_valid_in),
        .ub_wr_ready  (ub_wr_ready),
        .ub_wr_valid  (ub_wr_valid),
        .ub_wr_addr   (ub_wr_addr),
        .ub_wr_data   (ub_wr_data),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs set afterwards apply to the next edge, outputs sampled 1 unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic v1, input logic [15:0] d0, input logic [15:0] d1);
        vpu_valid_in = {v1, v0};
        vpu_data_in  = {d1, d0};
    endtask

    task automatic row(input string tag, input logic [15:0] a, input logic [15:0] d0, input logic [15:0] d1);
        chk({tag, "_vld"}, 32'(ub_wr_valid), 32'd1);
        chk({tag, "_addr"}, 32'(ub_wr_addr), 32'(a));
        chk({tag, "_data"}, ub_wr_data, {d1, d0});
    endtask

    task automatic kick(input logic [15:0] b, input logic [15:0] n);
        start = 1'b1; base_addr = b; num_rows = n;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0;
        ub_wr_ready = 1'b1;
        drive(0, 0, 16'h0, 16'h0);
        #1;
        step(); step();
        rst = 1'b0;
        chk("rst_vld", 32'(ub_wr_valid), 32'd0);
        chk("rst_addr", 32'(ub_wr_addr), 32'd0);
        chk("rst_data", ub_wr_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // 1: col1 lags col0 by one cycle
        kick(16'h0010, 16'd3);
        chk("t1_busy", 32'(busy), 32'd1);
        drive(1, 0, 16'd1, 16'd0); step();
        chk("t1_skew_vld", 32'(ub_wr_valid), 32'd0);
        drive(1, 1, 16'd3, 16'd2); step();
        row("t1_r0", 16'h0010, 16'd1, 16'd2);
        drive(1, 1, 16'd5, 16'd4); step();
        row("t1_r1", 16'h0011, 16'd3, 16'd4);
        drive(0, 1, 16'd0, 16'd6); step();
        row("t1_r2", 16'h0012, 16'd5, 16'd6);
        drive(0, 0, 16'd0, 16'd0); step();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_done_vld", 32'(ub_wr_valid), 32'd0);
        chk("t1_done_busy", 32'(busy), 32'd1);
        step();
        chk("t1_done_off", 32'(done), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // 2: UB stall while four words per column arrive
        kick(16'h0040, 16'd4);
        ub_wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 16'(16'h10 + i), 16'(16'h20 + i)); step();
            row("t2_stall", 16'h0040, 16'h0010, 16'h0020);
        end
        drive(0, 0, 16'd0, 16'd0); step();
        row("t2_hold", 16'h0040, 16'h0010, 16'h0020);
        chk("t2_ovf", 32'(overflow), 32'd0);
        ub_wr_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            row("t2_drain", 16'(16'h40 + r), 16'(16'h10 + r), 16'(16'h20 + r));
            step();
        end
        chk("t2_done", 32'(done), 32'd1);
        step();

        // 3: col0 overrun with col1 silent
        kick(16'h0080, 16'd8);
        for (int i = 1; i <= 5; i++) begin
            drive(1, 0, 16'(i), 16'd0); step();
            chk("t3_novld", 32'(ub_wr_valid), 32'd0);
            chk("t3_ovf", 32'(overflow), (i == 5) ? 32'd1 : 32'd0);
        end
        drive(0, 0, 16'd0, 16'd0);
        step(); step(); step();
        chk("t3_ovf_hold", 32'(overflow), 32'd1);
        chk("t3_head", 32'(ub_wr_data[15:0]), 32'd1);
        for (int j = 0; j < 4; j++) begin
            drive(0, 1, 16'd0, 16'(16'h11 + j)); step();
            row("t3_col0", 16'(16'h80 + j), 16'(1 + j), 16'(16'h11 + j));
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 16'(16'h31 + k), 16'(16'h41 + k)); step();
            row("t3_tail", 16'(16'h84 + k), 16'(16'h31 + k), 16'(16'h41 + k));
        end
        drive(0, 0, 16'd0, 16'd0); step();
        chk("t3_done", 32'(done), 32'd1);
        step();
        chk("t3_idle_ovf", 32'(overflow), 32'd1);
        chk("t3_idle_busy", 32'(busy), 32'd0);

        // 4: zero-row transfer; accepted start clears overflow
        kick(16'h0099, 16'd0);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_vld", 32'(ub_wr_valid), 32'd0);
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        step();
        chk("t4_done_off", 32'(done), 32'd0);
        chk("t4_vld2", 32'(ub_wr_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);

        // 5: idle valids dropped, start in RUN ignored, address wrap
        drive(1, 1, 16'h00AA, 16'h00BB); step(); step();
        chk("t5_idle_ovf", 32'(overflow), 32'd0);
        drive(0, 0, 16'd0, 16'd0);
        kick(16'hFFFF, 16'd2);
        chk("t5_empty", 32'(ub_wr_valid), 32'd0);
        start = 1'b1; base_addr = 16'h1234; num_rows = 16'd7;
        drive(1, 1, 16'd1, 16'd2); step();
        start = 1'b0;
        row("t5_r0", 16'hFFFF, 16'd1, 16'd2);
        drive(1, 1, 16'd3, 16'd4); step();
        row("t5_r1", 16'h0000, 16'd3, 16'd4);
        drive(0, 0, 16'd0, 16'd0); step();
        chk("t5_done", 32'(done), 32'd1);
        step();

        // 6: reset mid-transfer, then a fresh one-row transfer
        kick(16'h0050, 16'd3);
        drive(1, 1, 16'h0061, 16'h0071); step();
        row("t6_r0", 16'h0050, 16'h0061, 16'h0071);
        drive(1, 1, 16'h0062, 16'h0072); step();
        row("t6_r1", 16'h0051, 16'h0062, 16'h0072);
        rst = 1'b1; drive(0, 0, 16'd0, 16'd0); step();
        rst = 1'b0;
        chk("t6_rst_vld", 32'(ub_wr_valid), 32'd0);
        chk("t6_rst_addr", 32'(ub_wr_addr), 32'd0);
        chk("t6_rst_data", ub_wr_data, 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        kick(16'h0020, 16'd1);
        chk("t6_empty", 32'(ub_wr_valid), 32'd0);
        drive(1, 1, 16'h000A, 16'h000B); step();
        row("t6_fresh", 16'h0020, 16'h000A, 16'h000B);
        drive(0, 0, 16'd0, 16'd0); step();
        chk("t6_done", 32'(done), 32'd1);
        step();
        chk("t6_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
